// File: rtl/sm4_host_ctrl.sv
// Initiator-side sequencer for the sm4 core: takes enc/dec requests, runs key expansion
// only on key change, drives the core controls and returns the result with a watchdog abort.
module sm4_host_ctrl #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_dec,
  input  logic [127:0] req_key,
  input  logic [127:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         sm4_enable,
  output logic         key_exp_enable,
  output logic [127:0] key_in,
  output logic [127:0] data_in,
  output logic         enc_dec_enable,
  output logic         enc_dec,
  input  logic         key_exp_out,
  input  logic         ready_out,
  input  logic [127:0] res_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_KEXP, S_CRYPT, S_RESP, S_RELEASE
  } state_e;

  state_e                state_q, state_d;
  logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
  logic                  cache_vld_q, cache_vld_d;
  logic [127:0]          key_q, key_d, data_q, data_d, rsp_data_q, rsp_data_d;
  logic                  dec_q, dec_d, rsp_err_q, rsp_err_d;
  logic                  sm4_en_q, sm4_en_d, kexp_en_q, kexp_en_d;
  logic                  req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d, ed_en_q, ed_en_d;
  logic                  wdog_hit, cache_hit, abort;

  assign wdog_hit  = (wdog_q == TIMEOUT_W'(TIMEOUT));
  assign cache_hit = cache_vld_q && (req_key == key_q);

  // Next-state, datapath latches and registered output decode
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    cache_vld_d = cache_vld_q;
    key_d       = key_q;
    data_d      = data_q;
    dec_d       = dec_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    sm4_en_d    = sm4_en_q;
    kexp_en_d   = kexp_en_q;
    abort       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          key_d     = req_key;
          data_d    = req_data;
          dec_d     = req_dec;
          rsp_err_d = 1'b0;
          if (cache_hit) begin
            state_d = S_CRYPT;
          end else begin
            state_d     = S_FLUSH;
            sm4_en_d    = 1'b0;
            kexp_en_d   = 1'b0;
            cache_vld_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        state_d   = S_KEXP;
        sm4_en_d  = 1'b1;
        kexp_en_d = 1'b1;
      end
      S_KEXP: begin
        if (wdog_hit) begin
          abort = 1'b1;
        end else if (key_exp_out) begin
          cache_vld_d = 1'b1;
          state_d     = S_CRYPT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_CRYPT: begin
        // wdog_q==0 marks the first CRYPT cycle, where ready_out may still be stale
        if (wdog_hit) begin
          abort = 1'b1;
        end else if (ready_out && (wdog_q != '0)) begin
          rsp_data_d = res_out;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = rsp_err_q ? S_IDLE : S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (wdog_hit) begin
          abort = 1'b1;
        end else if (!ready_out) begin
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog abort flushes the core and reports an error response
    if (abort) begin
      rsp_err_d   = 1'b1;
      rsp_data_d  = '0;
      cache_vld_d = 1'b0;
      sm4_en_d    = 1'b0;
      kexp_en_d   = 1'b0;
      state_d     = S_RESP;
    end

    if (state_d != state_q) begin
      wdog_d = '0;
    end

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    ed_en_d     = (state_d == S_CRYPT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wdog_q      <= '0;
      cache_vld_q <= 1'b0;
      key_q       <= '0;
      data_q      <= '0;
      dec_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      sm4_en_q    <= 1'b0;
      kexp_en_q   <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      ed_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      cache_vld_q <= cache_vld_d;
      key_q       <= key_d;
      data_q      <= data_d;
      dec_q       <= dec_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      sm4_en_q    <= sm4_en_d;
      kexp_en_q   <= kexp_en_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      ed_en_q     <= ed_en_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign busy           = busy_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign sm4_enable     = sm4_en_q;
  assign key_exp_enable = kexp_en_q;
  assign key_in         = key_q;
  assign data_in        = data_q;
  assign enc_dec        = dec_q;
  assign enc_dec_enable = ed_en_q;

endmodule

// File: tb/tb_sm4_host_ctrl.sv
// Bench for sm4_host_ctrl: behavioural sm4 core stub, transaction scoreboard with a key-cache
// model, per-cycle protocol checks and directed scenarios with literal expectations.
module tb_sm4_host_ctrl;

  localparam int unsigned TK      = 6;   // stub: key_exp_out rises TK edges after enable rise
  localparam int unsigned TC      = 5;   // stub: ready_out rises TC edges after enable rise
  localparam int unsigned TIMEOUT = 15;

  localparam logic [127:0] K1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C1 = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] K2 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] K3 = 128'h55aa55aa00ff00ff1234567890abcdef;
  localparam logic [127:0] D2 = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_dec = 1'b0, rsp_ready = 1'b0;
  logic [127:0] req_key = '0, req_data = '0;
  logic req_ready, rsp_valid, rsp_err, busy, sm4_enable, key_exp_enable;
  logic enc_dec_enable, enc_dec;
  logic [127:0] rsp_data, key_in, data_in;
  logic key_exp_out, ready_out;
  logic [127:0] res_out;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sm4_host_ctrl #(.TIMEOUT_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dec(req_dec),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .sm4_enable(sm4_enable), .key_exp_enable(key_exp_enable),
    .key_in(key_in), .data_in(data_in), .enc_dec_enable(enc_dec_enable), .enc_dec(enc_dec),
    .key_exp_out(key_exp_out), .ready_out(ready_out), .res_out(res_out)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference cipher: known SM4 vector pair, otherwise a reversible stand-in
  function automatic logic [127:0] sm4_ref(input logic [127:0] k, input logic [127:0] d,
                                           input logic dec);
    if (k == K1 && d == K1 && !dec) return C1;
    if (k == K1 && d == C1 && dec)  return K1;
    return d ^ k ^ {128{dec}};
  endfunction

  // Core stub
  logic stub_hang = 1'b0;
  int   ready_hold = 0;
  int   kcnt, ccnt, hcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_exp_out <= 1'b0; ready_out <= 1'b0; res_out <= '0;
      kcnt <= 0; ccnt <= 0; hcnt <= 0;
    end else begin
      if (!sm4_enable || !key_exp_enable) begin
        kcnt <= 0; key_exp_out <= 1'b0;
      end else if (!stub_hang) begin
        kcnt <= kcnt + 1;
        if (kcnt + 1 >= TK) key_exp_out <= 1'b1;
      end
      if (enc_dec_enable) begin
        hcnt <= 0;
        ccnt <= ccnt + 1;
        if (ccnt + 1 >= TC) begin
          ready_out <= 1'b1;
          res_out   <= sm4_ref(key_in, data_in, enc_dec);
        end
      end else begin
        ccnt <= 0;
        if (ready_out) begin
          if (hcnt >= ready_hold) ready_out <= 1'b0;
          else hcnt <= hcnt + 1;
        end
      end
    end
  end

  // Scoreboard and key-cache model
  typedef struct {
    logic [127:0] data;
    logic         err;
    logic         hit;
    logic [127:0] key;
    logic         dec;
  } exp_t;
  exp_t exp_q[$];
  logic [127:0] m_key = '0;
  logic m_vld = 1'b0;
  logic in_txn = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0, post_chk = 1'b0, last_err = 1'b0;
  logic [127:0] prev_data = '0;
  logic prev_err = 1'b0;
  int txn_cyc = 0, flush_cnt = 0, kexp_cnt = 0, cyc_rst = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_vld = 1'b0; in_txn = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; post_chk = 1'b0;
      cyc_rst = 0;
    end else begin
      cyc_rst++;
      if (cyc_rst > 1) chk("req_ready_vs_busy", 128'(req_ready), 128'(!busy));
      if (rsp_valid) chk("enc_en_in_resp", 128'(enc_dec_enable), 128'(0));
      if (post_chk) begin
        chk("busy_after_handshake", 128'(busy), 128'(!last_err));
        post_chk = 1'b0;
      end
      if (in_txn) begin
        txn_cyc++;
        if (busy && !sm4_enable && !rsp_valid) flush_cnt++;
        if (key_exp_enable && !rsp_valid) kexp_cnt++;
      end
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 128'(1), 128'(0));
        end else begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_err", 128'(rsp_err), 128'(exp_q[0].err));
          chk("key_in", key_in, exp_q[0].key);
          chk("enc_dec", 128'(enc_dec), 128'(exp_q[0].dec));
          chk("flush_cycles", 128'(flush_cnt), 128'(exp_q[0].hit ? 0 : 1));
          if (exp_q[0].err)
            chk("kexp_cycles_to_abort", 128'(kexp_cnt), 128'(TIMEOUT + 1));
          else
            chk("latency", 128'(txn_cyc), 128'(exp_q[0].hit ? TC + 2 : TK + TC + 4));
        end
      end else if (rsp_valid && prev_valid && !prev_hs) begin
        chk("rsp_data_stable", rsp_data, prev_data);
        chk("rsp_err_stable", 128'(rsp_err), 128'(prev_err));
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        last_err = exp_q[0].err;
        void'(exp_q.pop_front());
        in_txn   = 1'b0;
        post_chk = 1'b1;
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e.hit  = m_vld && (req_key == m_key);
        e.err  = stub_hang && !e.hit;
        e.data = e.err ? '0 : sm4_ref(req_key, req_data, req_dec);
        e.key  = req_key;
        e.dec  = req_dec;
        exp_q.push_back(e);
        m_key = req_key; m_vld = !e.err;
        in_txn = 1'b1; txn_cyc = 0; flush_cnt = 0; kexp_cnt = 0;
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_data  = rsp_data;
      prev_err   = rsp_err;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    chk({tag, "_rsp_data"}, rsp_data, 128'(0));
    chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_sm4_enable"}, 128'(sm4_enable), 128'(0));
    chk({tag, "_key_exp_enable"}, 128'(key_exp_enable), 128'(0));
    chk({tag, "_key_in"}, key_in, 128'(0));
    chk({tag, "_data_in"}, data_in, 128'(0));
    chk({tag, "_enc_dec_enable"}, 128'(enc_dec_enable), 128'(0));
    chk({tag, "_enc_dec"}, 128'(enc_dec), 128'(0));
  endtask

  task automatic send_req(input logic [127:0] k, input logic [127:0] d, input logic dec);
    int n = 0;
    @(posedge clk); #1;
    req_key = k; req_data = d; req_dec = dec; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_accept_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int bp, output logic [127:0] rd, output logic re);
    int n = 0;
    rd = '0; re = 1'b0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 128'(0), 128'(1));
      return;
    end
    rd = rsp_data; re = rsp_err;
    repeat (bp) begin
      @(posedge clk);
      #1 chk("req_ready_under_backpressure", 128'(req_ready), 128'(0));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] rd;
    logic re;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Known-answer encrypt, then decrypt with the cached key
    send_req(K1, K1, 1'b0); get_rsp(0, rd, re);
    chk("enc_kat", rd, C1);
    send_req(K1, C1, 1'b1); get_rsp(0, rd, re);
    chk("dec_kat", rd, K1);

    // Key change, then cached key under 20 cycles of backpressure
    send_req(K2, D2, 1'b0); get_rsp(0, rd, re);
    send_req(K2, D2, 1'b1); get_rsp(20, rd, re);

    // Core keeps ready_out high after the request: release must wait
    ready_hold = 3;
    send_req(K2, K1, 1'b0); get_rsp(0, rd, re);
    ready_hold = 0;

    // Key expansion never completes: watchdog abort
    stub_hang = 1'b1;
    send_req(K3, D2, 1'b0); get_rsp(0, rd, re);
    chk("abort_err", 128'(re), 128'(1));
    chk("abort_data", rd, 128'(0));
    stub_hang = 1'b0;
    send_req(K3, D2, 1'b0); get_rsp(0, rd, re);
    chk("after_abort_err", 128'(re), 128'(0));

    // Reset asserted while the cached-key request is in CRYPT
    send_req(K3, K1, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_all_zero("midop_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send_req(K1, K1, 1'b0); get_rsp(0, rd, re);
    chk("post_reset_enc_kat", rd, C1);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
